// File: rtl/ball_bounce_pkg.sv
// Shared playfield geometry, serve point and FSM state type for the ball
// direction/life controller and its collision detector.
package ball_bounce_pkg;

  localparam int SCREEN_W  = 160;
  localparam int SCREEN_H  = 120;
  localparam int BALL_SIZE = 2;
  localparam int PLAT_Y    = 112;
  localparam int PLAT_W    = 16;
  localparam int PLAT_HALF = PLAT_W / 2;

  // Serve point used by the position counters while ball_rst_n is low.
  localparam int SERVE_X = SCREEN_W / 2 - BALL_SIZE / 2;
  localparam int SERVE_Y = PLAT_Y - 4 * BALL_SIZE;

  localparam int LIVES_DEF      = 3;
  localparam int LOCK_TICKS_DEF = 2;

  typedef enum logic [1:0] {
    ST_SERVE = 2'd0,
    ST_PLAY  = 2'd1,
    ST_LOST  = 2'd2,
    ST_OVER  = 2'd3
  } state_e;

  function automatic logic [10:0] ext11(input logic [9:0] v);
    return {1'b0, v};
  endfunction

endpackage

// File: rtl/ball_bounce_collide_detect.sv
// Combinational collision flags for the current ball position; all compares
// are done one bit wider than the coordinates so additions never wrap.
module ball_bounce_collide_detect
  import ball_bounce_pkg::*;
(
  input  logic [9:0] x,
  input  logic [9:0] y,
  input  logic [9:0] platx,
  input  logic       y_du,
  output logic       miss,
  output logic       plat_hit,
  output logic       wall_l,
  output logic       wall_r,
  output logic       wall_t
);

  logic [10:0] x_w;
  logic [10:0] y_w;
  logic [10:0] px_w;

  assign x_w  = ext11(x);
  assign y_w  = ext11(y);
  assign px_w = ext11(platx);

  assign miss     = (y_w >= 11'(SCREEN_H - BALL_SIZE));
  // Only a descending ball whose bottom edge reaches the platform row bounces.
  assign plat_hit = y_du
                 && (y_w + 11'(BALL_SIZE) >= 11'(PLAT_Y))
                 && (y_w < 11'(PLAT_Y))
                 && (x_w + 11'(BALL_SIZE) > px_w)
                 && (x_w < px_w + 11'(PLAT_W));
  assign wall_l   = (x_w == 11'd0);
  assign wall_r   = (x_w >= 11'(SCREEN_W - BALL_SIZE));
  assign wall_t   = (y_w == 11'd0);

endmodule

// File: rtl/ball_bounce.sv
// Ball direction and life controller: serve/play/lost/over FSM, brick-hit
// pending/lock handling, lives counter and control of the position counters.
module ball_bounce
  import ball_bounce_pkg::*;
#(
  parameter int LIVES      = LIVES_DEF,
  parameter int LOCK_TICKS = LOCK_TICKS_DEF
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       enable,
  input  logic       launch,
  input  logic [9:0] x,
  input  logic [9:0] y,
  input  logic [9:0] platx,
  input  logic       brick_hit,
  input  logic       brick_side,
  output logic       x_du,
  output logic       y_du,
  output logic       ball_en,
  output logic       ball_rst_n,
  output logic       plat_col,
  output logic       lose,
  output logic       game_over,
  output logic [2:0] lives,
  output state_e     dbg_state
);

  localparam int LOCK_W = $clog2(LOCK_TICKS + 1);

  state_e            state_q, state_d;
  logic              x_du_q, x_du_d;
  logic              y_du_q, y_du_d;
  logic              plat_col_q, plat_col_d;
  logic              pending_q, pending_d;
  logic              side_q, side_d;
  logic [2:0]        lives_q, lives_d;
  logic [LOCK_W-1:0] lock_q, lock_d;

  logic miss, plat_hit, wall_l, wall_r, wall_t;
  logic hit_ok, pend_eff, side_eff;

  ball_bounce_collide_detect u_collide (
    .x        (x),
    .y        (y),
    .platx    (platx),
    .y_du     (y_du_q),
    .miss     (miss),
    .plat_hit (plat_hit),
    .wall_l   (wall_l),
    .wall_r   (wall_r),
    .wall_t   (wall_t)
  );

  always_comb begin
    state_d    = state_q;
    x_du_d     = x_du_q;
    y_du_d     = y_du_q;
    plat_col_d = 1'b0;
    pending_d  = pending_q;
    side_d     = side_q;
    lives_d    = lives_q;
    lock_d     = lock_q;
    hit_ok     = 1'b0;
    pend_eff   = 1'b0;
    side_eff   = side_q;

    unique case (state_q)
      ST_SERVE: begin
        x_du_d    = 1'b1;
        y_du_d    = 1'b0;
        pending_d = 1'b0;
        lock_d    = '0;
        if (launch) state_d = ST_PLAY;
      end
      ST_PLAY: begin
        // A hit arriving on the tick itself is treated as already pending.
        hit_ok   = brick_hit && (lock_q == '0);
        pend_eff = pending_q || hit_ok;
        side_eff = hit_ok ? brick_side : side_q;
        if (hit_ok) begin
          pending_d = 1'b1;
          side_d    = brick_side;
        end
        if (enable) begin
          if (miss) begin
            state_d = ST_LOST;
          end else begin
            if (lock_q != '0) lock_d = lock_q - LOCK_W'(1);
            if (pend_eff && (lock_q == '0)) begin
              pending_d = 1'b0;
              lock_d    = LOCK_W'(LOCK_TICKS);
              if (side_eff) x_du_d = ~x_du_q;
              else          y_du_d = ~y_du_q;
            end
            // Platform and wall assignments override any brick toggle.
            if (plat_hit) begin
              y_du_d     = 1'b0;
              plat_col_d = 1'b1;
            end
            if (wall_l) x_du_d = 1'b1;
            if (wall_r) x_du_d = 1'b0;
            if (wall_t) y_du_d = 1'b1;
          end
        end
      end
      ST_LOST: begin
        lives_d   = lives_q - 3'd1;
        pending_d = 1'b0;
        lock_d    = '0;
        x_du_d    = 1'b1;
        y_du_d    = 1'b0;
        state_d   = (lives_q == 3'd1) ? ST_OVER : ST_SERVE;
      end
      ST_OVER: begin
        state_d = ST_OVER;
      end
      default: begin
        state_d = ST_SERVE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= ST_SERVE;
      x_du_q     <= 1'b1;
      y_du_q     <= 1'b0;
      plat_col_q <= 1'b0;
      pending_q  <= 1'b0;
      side_q     <= 1'b0;
      lives_q    <= 3'(LIVES);
      lock_q     <= '0;
    end else begin
      state_q    <= state_d;
      x_du_q     <= x_du_d;
      y_du_q     <= y_du_d;
      plat_col_q <= plat_col_d;
      pending_q  <= pending_d;
      side_q     <= side_d;
      lives_q    <= lives_d;
      lock_q     <= lock_d;
    end
  end

  assign x_du       = x_du_q;
  assign y_du       = y_du_q;
  assign plat_col   = plat_col_q;
  assign lives      = lives_q;
  assign ball_rst_n = (state_q == ST_PLAY);
  assign ball_en    = (state_q == ST_PLAY) && enable;
  assign lose       = (state_q == ST_LOST);
  assign game_over  = (state_q == ST_OVER);
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_ball_bounce.sv
// Bench for ball_bounce: directed scenarios plus randomized play, with every
// cycle checked against a rule-level model of the controller.
module tb_ball_bounce;
  import ball_bounce_pkg::*;

  localparam int LIVES_N = 3;
  localparam int LOCK_N  = 2;
  localparam logic [9:0] SAFE_X = 10'd80;
  localparam logic [9:0] SAFE_Y = 10'd50;
  localparam logic [9:0] SAFE_P = 10'd0;

  localparam int S_SERVE = 0;
  localparam int S_PLAY  = 1;
  localparam int S_LOST  = 2;
  localparam int S_OVER  = 3;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       enable = 1'b0;
  logic       launch = 1'b0;
  logic [9:0] x = SAFE_X;
  logic [9:0] y = SAFE_Y;
  logic [9:0] platx = SAFE_P;
  logic       brick_hit = 1'b0;
  logic       brick_side = 1'b0;
  logic       x_du, y_du, ball_en, ball_rst_n, plat_col, lose, game_over;
  logic [2:0] lives;
  state_e     dbg_state;

  int vec_cnt = 0;
  int err_cnt = 0;
  bit mon_en  = 1'b0;

  ball_bounce #(.LIVES(LIVES_N), .LOCK_TICKS(LOCK_N)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .enable     (enable),
    .launch     (launch),
    .x          (x),
    .y          (y),
    .platx      (platx),
    .brick_hit  (brick_hit),
    .brick_side (brick_side),
    .x_du       (x_du),
    .y_du       (y_du),
    .ball_en    (ball_en),
    .ball_rst_n (ball_rst_n),
    .plat_col   (plat_col),
    .lose       (lose),
    .game_over  (game_over),
    .lives      (lives),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int m_state, m_lives, m_lock;
  bit m_xdu, m_ydu, m_pend, m_side, m_platcol;

  always @(posedge clk) begin
    int xi, yi, pi;
    bit nx, ny, x_set, y_set;
    xi = int'(x); yi = int'(y); pi = int'(platx);
    m_platcol = 1'b0;
    if (!resetn) begin
      m_state = S_SERVE; m_xdu = 1'b1; m_ydu = 1'b0; m_lives = LIVES_N;
      m_pend = 1'b0; m_side = 1'b0; m_lock = 0;
    end else if (m_state == S_SERVE) begin
      if (launch) m_state = S_PLAY;
    end else if (m_state == S_PLAY) begin
      if (brick_hit && m_lock == 0) begin
        m_pend = 1'b1; m_side = brick_side;
      end
      if (enable) begin
        if (yi >= SCREEN_H - BALL_SIZE) begin
          m_state = S_LOST;
        end else begin
          nx = m_xdu; ny = m_ydu; x_set = 1'b0; y_set = 1'b0;
          if (m_ydu && yi + BALL_SIZE >= PLAT_Y && yi < PLAT_Y &&
              xi + BALL_SIZE > pi && xi < pi + PLAT_W) begin
            ny = 1'b0; y_set = 1'b1; m_platcol = 1'b1;
          end
          if (xi == 0) begin nx = 1'b1; x_set = 1'b1; end
          if (xi >= SCREEN_W - BALL_SIZE) begin nx = 1'b0; x_set = 1'b1; end
          if (yi == 0) begin ny = 1'b1; y_set = 1'b1; end
          if (m_pend && m_lock == 0) begin
            if (m_side && !x_set) nx = !m_xdu;
            if (!m_side && !y_set) ny = !m_ydu;
            m_pend = 1'b0;
            m_lock = LOCK_N;
          end else if (m_lock > 0) begin
            m_lock = m_lock - 1;
          end
          m_xdu = nx; m_ydu = ny;
        end
      end
    end else if (m_state == S_LOST) begin
      m_lives = m_lives - 1;
      m_pend = 1'b0; m_lock = 0; m_xdu = 1'b1; m_ydu = 1'b0;
      m_state = (m_lives == 0) ? S_OVER : S_SERVE;
    end
  end

  // ---------------- scoreboard: every cycle vs model ----------------
  always @(negedge clk) begin
    logic [9:0] exp_v, act_v;
    if (mon_en) begin
      exp_v = {m_xdu, m_ydu, (m_state == S_PLAY) && enable, m_state == S_PLAY,
               m_platcol, m_state == S_LOST, m_state == S_OVER, 3'(m_lives)};
      act_v = {x_du, y_du, ball_en, ball_rst_n, plat_col, lose, game_over, lives};
      vec_cnt++;
      if (act_v !== exp_v) begin
        err_cnt++;
        $display("FAIL model_cycle t=%0t: {xdu,ydu,en,rstn,pc,lose,go,lives}=%b expected %b",
                 $time, act_v, exp_v);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic en, input logic ln, input logic bh, input logic bs,
                       input logic [9:0] xv, input logic [9:0] yv, input logic [9:0] pv);
    @(posedge clk); #1;
    enable = en; launch = ln; brick_hit = bh; brick_side = bs;
    x = xv; y = yv; platx = pv;
  endtask

  task automatic settle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, SAFE_X, SAFE_Y, SAFE_P);
    @(negedge clk);
  endtask

  task automatic tick(input logic [9:0] xv, input logic [9:0] yv, input logic [9:0] pv,
                      input logic bh, input logic bs);
    drive(1'b1, 1'b0, bh, bs, xv, yv, pv);
    settle();
  endtask

  task automatic hit(input logic bs);
    drive(1'b0, 1'b0, 1'b1, bs, SAFE_X, SAFE_Y, SAFE_P);
    settle();
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    resetn = 1'b0;
    enable = 1'b0; launch = 1'b0; brick_hit = 1'b0;
    @(posedge clk); #1;
    mon_en = 1'b1;
    resetn = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    @(posedge clk); @(posedge clk); #1;
    mon_en = 1'b1;
    @(negedge clk);
    vec_cnt++;
    if ({x_du, y_du, ball_rst_n, ball_en, plat_col, lose, game_over, lives} !== {7'b1000000, 3'd3}) begin
      err_cnt++;
      $display("FAIL reset_values: got %b_%0d expected 1000000_3",
               {x_du, y_du, ball_rst_n, ball_en, plat_col, lose, game_over}, lives);
    end
    @(posedge clk); #1;
    resetn = 1'b1;
  endtask

  task automatic test_launch();
    drive(1'b0, 1'b1, 1'b0, 1'b0, SAFE_X, SAFE_Y, SAFE_P);
    settle();
    vec_cnt++;
    if ({ball_rst_n, x_du, y_du, lives} !== {3'b110, 3'd3} || dbg_state !== ST_PLAY) begin
      err_cnt++;
      $display("FAIL launch_play: rstn/xdu/ydu=%b lives=%0d state=%0d expected 110 3 PLAY",
               {ball_rst_n, x_du, y_du}, lives, dbg_state);
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0, SAFE_X, SAFE_Y, SAFE_P);
    @(negedge clk);
    vec_cnt++;
    if (ball_en !== 1'b1) begin
      err_cnt++; $display("FAIL ball_en_high: ball_en=%b expected 1", ball_en);
    end
    settle();
    vec_cnt++;
    if (ball_en !== 1'b0) begin
      err_cnt++; $display("FAIL ball_en_low: ball_en=%b expected 0", ball_en);
    end
  endtask

  task automatic test_walls();
    tick(10'd158, SAFE_Y, SAFE_P, 1'b0, 1'b0);
    vec_cnt++;
    if (x_du !== 1'b0) begin err_cnt++; $display("FAIL wall_right: x_du=%b expected 0", x_du); end
    tick(10'd0, SAFE_Y, SAFE_P, 1'b0, 1'b0);
    vec_cnt++;
    if (x_du !== 1'b1) begin err_cnt++; $display("FAIL wall_left: x_du=%b expected 1", x_du); end
    tick(SAFE_X, 10'd0, SAFE_P, 1'b0, 1'b0);
    vec_cnt++;
    if (y_du !== 1'b1) begin err_cnt++; $display("FAIL wall_top: y_du=%b expected 1", y_du); end
  endtask

  task automatic test_platform();
    tick(10'd45, 10'd110, 10'd40, 1'b0, 1'b0);
    vec_cnt++;
    if ({y_du, plat_col} !== 2'b01) begin
      err_cnt++; $display("FAIL plat_bounce: ydu/plat_col=%b expected 01", {y_du, plat_col});
    end
    settle();
    vec_cnt++;
    if (plat_col !== 1'b0) begin err_cnt++; $display("FAIL plat_pulse_width: plat_col=%b expected 0", plat_col); end
    tick(SAFE_X, 10'd0, SAFE_P, 1'b0, 1'b0);
    tick(10'd60, 10'd110, 10'd40, 1'b0, 1'b0);
    vec_cnt++;
    if ({y_du, plat_col} !== 2'b10) begin
      err_cnt++; $display("FAIL plat_miss_side: ydu/plat_col=%b expected 10", {y_du, plat_col});
    end
  endtask

  task automatic test_brick_lock();
    hit(1'b0);
    tick(SAFE_X, SAFE_Y, SAFE_P, 1'b0, 1'b0);
    vec_cnt++;
    if (y_du !== 1'b0) begin err_cnt++; $display("FAIL brick_apply: y_du=%b expected 0", y_du); end
    tick(SAFE_X, SAFE_Y, SAFE_P, 1'b0, 1'b0);
    hit(1'b0);
    tick(SAFE_X, SAFE_Y, SAFE_P, 1'b0, 1'b0);
    vec_cnt++;
    if (y_du !== 1'b0) begin err_cnt++; $display("FAIL brick_locked: y_du=%b expected 0", y_du); end
    hit(1'b0);
    tick(SAFE_X, SAFE_Y, SAFE_P, 1'b0, 1'b0);
    vec_cnt++;
    if (y_du !== 1'b1) begin err_cnt++; $display("FAIL brick_unlocked: y_du=%b expected 1", y_du); end
    tick(SAFE_X, SAFE_Y, SAFE_P, 1'b0, 1'b0);
    tick(SAFE_X, SAFE_Y, SAFE_P, 1'b0, 1'b0);
  endtask

  task automatic test_wall_wins();
    tick(10'd158, SAFE_Y, SAFE_P, 1'b0, 1'b0);
    tick(10'd0, SAFE_Y, SAFE_P, 1'b1, 1'b1);
    vec_cnt++;
    if (x_du !== 1'b1) begin err_cnt++; $display("FAIL wall_wins_from0: x_du=%b expected 1", x_du); end
    repeat (3) tick(SAFE_X, SAFE_Y, SAFE_P, 1'b0, 1'b0);
    vec_cnt++;
    if (x_du !== 1'b1) begin err_cnt++; $display("FAIL pending_cleared_a: x_du=%b expected 1", x_du); end
    tick(10'd0, SAFE_Y, SAFE_P, 1'b1, 1'b1);
    vec_cnt++;
    if (x_du !== 1'b1) begin err_cnt++; $display("FAIL wall_wins_from1: x_du=%b expected 1", x_du); end
    repeat (3) tick(SAFE_X, SAFE_Y, SAFE_P, 1'b0, 1'b0);
    vec_cnt++;
    if (x_du !== 1'b1) begin err_cnt++; $display("FAIL pending_cleared_b: x_du=%b expected 1", x_du); end
  endtask

  task automatic test_lose();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b0, SAFE_X, SAFE_Y, SAFE_P);
      settle();
      tick(SAFE_X, 10'd118, SAFE_P, 1'b0, 1'b0);
      vec_cnt++;
      if ({lose, ball_rst_n} !== 2'b10 || lives !== 3'(3 - i)) begin
        err_cnt++;
        $display("FAIL lost_pulse_%0d: lose/rstn=%b lives=%0d expected 10 %0d", i, {lose, ball_rst_n}, lives, 3 - i);
      end
      settle();
      vec_cnt++;
      if ({lose, ball_rst_n, x_du, y_du} !== 4'b0010 || lives !== 3'(2 - i)) begin
        err_cnt++;
        $display("FAIL after_lost_%0d: lose/rstn/xdu/ydu=%b lives=%0d expected 0010 %0d",
                 i, {lose, ball_rst_n, x_du, y_du}, lives, 2 - i);
      end
    end
    vec_cnt++;
    if (game_over !== 1'b1 || lives !== 3'd0) begin
      err_cnt++; $display("FAIL game_over: game_over=%b lives=%0d expected 1 0", game_over, lives);
    end
    drive(1'b0, 1'b1, 1'b0, 1'b0, SAFE_X, SAFE_Y, SAFE_P);
    settle();
    drive(1'b1, 1'b0, 1'b0, 1'b0, SAFE_X, SAFE_Y, SAFE_P);
    @(negedge clk);
    vec_cnt++;
    if ({game_over, ball_rst_n, ball_en} !== 3'b100) begin
      err_cnt++; $display("FAIL over_holds: go/rstn/en=%b expected 100", {game_over, ball_rst_n, ball_en});
    end
    settle();
  endtask

  task automatic test_reset_mid_play();
    do_reset();
    drive(1'b0, 1'b1, 1'b0, 1'b0, SAFE_X, SAFE_Y, SAFE_P);
    settle();
    tick(10'd158, 10'd0, SAFE_P, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 10'd45, 10'd110, 10'd40);
    resetn = 1'b0;
    settle();
    vec_cnt++;
    if ({plat_col, lose, x_du, y_du, ball_rst_n} !== 5'b00100 || lives !== 3'd3) begin
      err_cnt++;
      $display("FAIL reset_mid_play: pc/lose/xdu/ydu/rstn=%b lives=%0d expected 00100 3",
               {plat_col, lose, x_du, y_du, ball_rst_n}, lives);
    end
    @(posedge clk); #1;
    resetn = 1'b1;
  endtask

  task automatic test_random();
    logic [9:0] rx, ry, rp;
    for (int n = 0; n < 4000; n++) begin
      rp = 10'($urandom_range(0, 150));
      case ($urandom_range(0, 5))
        0:       rx = 10'd0;
        1:       rx = 10'($urandom_range(156, 159));
        2:       rx = 10'(int'(rp) + $urandom_range(0, 20) - 3);
        3:       rx = 10'($urandom_range(0, 1023));
        default: rx = 10'($urandom_range(1, 155));
      endcase
      case ($urandom_range(0, 5))
        0:       ry = 10'd0;
        1:       ry = 10'($urandom_range(108, 113));
        2:       ry = 10'($urandom_range(116, 120));
        3:       ry = 10'($urandom_range(0, 1023));
        default: ry = 10'($urandom_range(1, 100));
      endcase
      if (ry >= 10'd116 && $urandom_range(0, 3) != 0) ry = 10'($urandom_range(1, 100));
      drive($urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0,
            1'($urandom_range(0, 1)), rx, ry, rp);
      if ($urandom_range(0, 299) == 0) resetn = 1'b0;
      else resetn = 1'b1;
    end
    settle();
    resetn = 1'b1;
    settle();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_launch();
    test_walls();
    test_platform();
    test_brick_lock();
    test_wall_wins();
    test_lose();
    test_reset_mid_play();
    test_random();
    @(negedge clk);
    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
